// File: rtl/mem_dma.sv
// Single-channel memory DMA: copies a block of words between two regions, or fills
// a region with one constant word. It writes one word per cycle through a write
// port fed by a combinational read port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for start; the request is latched on the start edge
//   XFER  | one word written per cycle, cursors and counter advancing
//   DONE  | one-cycle completion pulse, err shows whether the request was rejected
module mem_dma #(
    parameter int LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_val,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_we,
    output logic [31:0]      mem_addr0,
    output logic [31:0]      mem_wd0,
    output logic [31:0]      mem_addr1,
    input  logic [31:0]      mem_rd1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;

    logic [31:0]      src_cur;
    logic [31:0]      dst_cur;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             mode_q;
    logic [31:0]      fill_q;
    logic             err_q;
    logic             desc_q;

    logic             req_bad;
    logic             req_empty;
    logic             req_desc;
    logic [33:0]      src_end;
    logic [31:0]      span;
    logic [31:0]      src_init;
    logic [31:0]      dst_init;
    logic             last_word;

    // Request decode, evaluated on the raw inputs so it can be latched on the start edge.
    always_comb begin
        req_bad   = (~mode & (src_addr[1:0] != 2'b00)) | (dst_addr[1:0] != 2'b00);
        req_empty = (len == '0);
        // 34-bit end address so a source block near the top of memory cannot wrap the compare
        src_end   = {2'b00, src_addr} + 34'({len, 2'b00});
        req_desc  = ~mode & (dst_addr > src_addr) & ({2'b00, dst_addr} < src_end);
        span      = 32'({len - LEN_ONE, 2'b00});
        src_init  = req_desc ? (src_addr + span) : src_addr;
        dst_init  = req_desc ? (dst_addr + span) : dst_addr;
    end

    assign last_word = (cnt == (len_q - LEN_ONE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_cur <= '0;
            dst_cur <= '0;
            cnt     <= '0;
            len_q   <= '0;
            mode_q  <= 1'b0;
            fill_q  <= '0;
            err_q   <= 1'b0;
            desc_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        src_cur <= src_init;
                        dst_cur <= dst_init;
                        cnt     <= '0;
                        len_q   <= len;
                        mode_q  <= mode;
                        fill_q  <= fill_val;
                        err_q   <= req_bad;
                        desc_q  <= req_desc;
                    end
                end
                XFER: begin
                    src_cur <= desc_q ? (src_cur - 32'd4) : (src_cur + 32'd4);
                    dst_cur <= desc_q ? (dst_cur - 32'd4) : (dst_cur + 32'd4);
                    cnt     <= cnt + LEN_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (req_bad || req_empty) ? DONE : XFER;
                end
            end
            XFER: begin
                if (last_word) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_we    = 1'b0;
        mem_addr0 = '0;
        mem_addr1 = '0;
        mem_wd0   = '0;
        case (state)
            XFER: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr0 = dst_cur;
                // Fill never reads, so the read port is held at zero
                mem_addr1 = mode_q ? 32'd0 : src_cur;
                mem_wd0   = mode_q ? fill_q : mem_rd1;
            end
            DONE: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mem_dma.md
MEM_DMA -- requirements
Module: mem_dma

Interface
REQ-001 Parameter: LEN_W, 11, width of len; max transfer 2^(LEN_W-1) = 1024 words, one full data memory.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 mode  input  1  0 = copy, 1 = fill.
REQ-006 src_addr  input  32  source byte address, word-aligned.
REQ-007 dst_addr  input  32  destination byte address, word-aligned.
REQ-008 len  input  LEN_W  transfer length in words.
REQ-009 fill_val  input  32  word written in fill mode.
REQ-010 busy  output  1  high while words are being transferred.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  qualifies done: request rejected.
REQ-013 mem_we  output  1  write enable to the memory write/read port.
REQ-014 mem_addr0  output  32  write byte address.
REQ-015 mem_wd0  output  32  write data.
REQ-016 mem_addr1  output  32  read-only port byte address.
REQ-017 mem_rd1  input  32  combinational read data for mem_addr1, same cycle.

Function
REQ-018 The FSM SHALL have the states IDLE, XFER and DONE.
REQ-019 In IDLE, start=1 at an edge SHALL latch src_addr, dst_addr, len, mode and fill_val.
- Next state: DONE with err=1 if src_addr[1:0]!=0 (copy mode only) or dst_addr[1:0]!=0.
- Next state: DONE with err=0 if len==0.
- Otherwise next state: XFER.
REQ-020 start SHALL be ignored in XFER and DONE.
REQ-021 In XFER, the block SHALL write exactly one word per cycle.
- mem_we=1; mem_addr0 = destination cursor; mem_addr1 = source cursor.
- mem_wd0 = mem_rd1 (copy) or the latched fill_val (fill), combinationally.
REQ-022 At each XFER edge, the cursors SHALL step by 4, modulo 2^32, and a word counter SHALL increment.
- The edge committing word len-1 SHALL move to DONE.
- busy SHALL be high for exactly len cycles.
REQ-023 Copy direction SHALL be descending when dst > src (unsigned) and dst < src + 4*len; otherwise ascending.
- Descending: cursors start at base + 4*(len-1) and decrement.
- Fill mode SHALL always be ascending.
REQ-024 Outside XFER, mem_we, mem_addr0, mem_addr1 and mem_wd0 SHALL be 0.
REQ-025 DONE SHALL last one cycle, with done=1, busy=0 and err as latched; it then returns to IDLE.
- start in that cycle SHALL be ignored.
REQ-026 A new start SHALL be accepted in the first IDLE cycle after DONE.
- Minimum spacing between done and the next busy: 1 cycle.
REQ-027 A cursor crossing 0xFFFFFFFC SHALL wrap to 0; the memory decodes only the low index bits.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and clear the latched request, the counter and err.
- busy=0, done=0, err=0, and all mem_* outputs 0 from that edge.
- This SHALL apply in any state, including mid-XFER.
REQ-029 Words committed before the reset edge SHALL remain written; no further write SHALL occur.
REQ-030 reset SHALL take priority over start at the same edge.

Verification
REQ-031 Ascending copy: mem[0..3]=A,B,C,D; start with src=0x000, dst=0x100, len=4.
- busy for 4 cycles; mem_addr0 = 0x100, 0x104, 0x108, 0x10C.
- mem[64..67]=A..D; done=1, err=0 in cycle 5.
REQ-032 Overlapping copy: mem[0..5]=1,2,3,4,0,0; src=0x000, dst=0x008, len=4.
- Descending mem_addr0 = 0x014, 0x010, 0x00C, 0x008.
- Final mem[2..5]=1,2,3,4.
REQ-033 Fill: mode=1, dst=0x200, len=3, fill_val=0xDEADBEEF.
- mem[128..130]=0xDEADBEEF; mem_addr1 stays 0.
REQ-034 Rejects, both with done=1 one cycle after start and mem_we never asserted:
- len=0 -> err=0.
- src=0x002 with copy -> err=1.
REQ-035 Reset mid-transfer: reset asserted after 2 of 8 words.
- From the reset edge: mem_we=0, busy=0.
- Exactly 2 destination words changed.
- A following start is accepted normally.
REQ-036 start pulsed during XFER and during DONE SHALL be ignored.
- No second transfer; exactly one done pulse.
